latch_loader: RTL and testbench
===============================

// Module: latch_loader
//
// PURPOSE
//   Upstream driver for the 4-bit positive level-sensitive latch.
//   - Accepts words over a valid/ready handshake.
//   - Drives the latch data bus and its gate so every load obeys a programmable
//     setup / open / hold cycle window:
//       - data is stable before the gate opens;
//       - the gate stays high for a fixed number of cycles;
//       - data is held after the gate closes.
//   - The gate output is glitch-free (registered), because it feeds a level-sensitive enable.
//
// PARAMETERS
//   WIDTH      4  data width; matches the latch d/q width
//   SETUP_CYC  1  cycles lat_d is stable with lat_en low before the gate opens (>=1)
//   OPEN_CYC   2  cycles lat_en is held high (>=1)
//   HOLD_CYC   1  cycles lat_d is held with lat_en low after the gate closes (>=1)
//
// PORTS
//   clk       in   1      single clock, rising-edge
//   reset_n   in   1      asynchronous, active-low reset
//   in_valid  in   1      upstream word available
//   in_ready  out  1      loader can accept a word
//   in_data   in   WIDTH  word to load
//   flush     in   1      synchronous abort of the current load
//   lat_d     out  WIDTH  to latch d; registered
//   lat_en    out  1      to latch gate (latch clk port); registered, never combinational
//   busy      out  1      high whenever state != IDLE
//   done      out  1      one-cycle pulse: a load finished its full window
//
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - state = IDLE, lat_en = 0, lat_d = 0, done = 0, count = 0.
//     - in_ready = 1 after reset, since it is decoded from IDLE.
//   Handshake:
//     - in_ready = (state == IDLE) && !flush.
//     - Accept occurs when in_valid && in_ready at a rising edge (edge E0).
//     - Upstream data may change freely when not accepted.
//   FSM (IDLE -> SETUP -> OPEN -> HOLD -> IDLE):
//     - IDLE:  on accept, lat_d <= in_data, count <= SETUP_CYC-1, go to SETUP.
//     - SETUP: lat_en = 0. When count == 0, count <= OPEN_CYC-1, lat_en <= 1, go to OPEN.
//     - OPEN:  lat_en = 1. When count == 0, count <= HOLD_CYC-1, lat_en <= 0, go to HOLD.
//     - HOLD:  lat_en = 0. When count == 0, go to IDLE and done <= 1 (for one cycle).
//     - Otherwise the counter decrements each cycle.
//   Timing with defaults:
//     - lat_en rises at E0+1 and falls at E0+3.
//     - done is high during the cycle after E0+4.
//     - in_ready returns in that same cycle.
//   Back-to-back: a new accept may occur in the cycle done is high. No gap is required.
//   lat_d changes only at an accept edge. It holds its last value through IDLE and
//   through every phase of the window.
//   lat_en and lat_d never change on the same edge.
//   flush:
//     - At any edge, flush returns the FSM to IDLE, clears lat_en and count, and
//       suppresses done.
//     - lat_d is kept, so the latch may hold a partially-open value.
//     - flush has priority over accept and over phase advance.
//   Counter width is $clog2(max(SETUP_CYC,OPEN_CYC,HOLD_CYC)+1). The counter never wraps.
//   Parameter values < 1 trigger an elaboration-time $error.
//   Reset mid-window: lat_en drops immediately (asynchronously). No done pulse is produced.
//
// STRUCTURE
//   Package latch_pkg:
//     - typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} loader_state_t;
//     - default timing localparams.
//   Sub-module phase_counter:
//     - loadable down-counter with a zero flag.
//     - same clk/reset_n convention.
//   Top-level contents: FSM, data register, registered lat_en, done.
//
// TESTING (bind to the latch; check q)
//   1. Reset: reset_n=0 mid-OPEN -> lat_en=0, lat_d=0, busy=0 immediately; in_ready=1 after release.
//   2. Single load, defaults:
//      - stimulus: in_data=4'hA accepted at E0;
//      - lat_en=1 exactly for E0+1..E0+3;
//      - latch q=4'hA from E0+1; done at E0+4.
//   3. Back-to-back: 4'h3 then 4'hC, with in_valid held -> second accept in the done cycle;
//      q steps 3 -> C; no lat_en overlap with lat_d change.
//   4. Upstream stall: in_valid toggling while busy -> no extra accepts; lat_d stable.
//   5. Flush in OPEN (after E0+2) -> lat_en=0 at next edge; no done; idle; in_ready=1.
//   6. Params SETUP=3, OPEN=1, HOLD=2 -> lat_en high only E0+3..E0+4; done at E0+6.

Source files
------------

// File: rtl/latch_loader_pkg.sv
// Shared types and default timing for the latch loader.
package latch_loader_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} loader_state_t;

  localparam int unsigned DefWidth    = 4;
  localparam int unsigned DefSetupCyc = 1;
  localparam int unsigned DefOpenCyc  = 2;
  localparam int unsigned DefHoldCyc  = 1;

  // Largest of three phase lengths; sizes the shared phase counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/latch_loader_if.sv
// Upstream valid/ready word handshake into the latch loader.
interface latch_loader_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/latch_loader_phase_counter.sv
// Loadable saturating down-counter with a zero flag; times each window phase.
module latch_loader_phase_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  // Clear beats load; otherwise count down and stop at zero so it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/latch_loader.sv
// Drives a level-sensitive latch with a setup / open / hold window per accepted word.
module latch_loader
  import latch_loader_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned SETUP_CYC = DefSetupCyc,
  parameter int unsigned OPEN_CYC  = DefOpenCyc,
  parameter int unsigned HOLD_CYC  = DefHoldCyc
) (
  input  logic             clk,
  input  logic             reset_n,
  latch_loader_if.slave    bus,
  input  logic             flush,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_en,
  output logic             busy,
  output logic             done
);

  localparam int unsigned MaxCyc = max3(max3(SETUP_CYC, OPEN_CYC, HOLD_CYC), 1, 1);
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc + 1) : 1;

  if (SETUP_CYC < 1) begin : g_bad_setup
    $error("latch_loader: SETUP_CYC must be >= 1");
  end
  if (OPEN_CYC < 1) begin : g_bad_open
    $error("latch_loader: OPEN_CYC must be >= 1");
  end
  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("latch_loader: HOLD_CYC must be >= 1");
  end

  loader_state_t    state_q, state_d;
  logic [WIDTH-1:0] lat_d_q, lat_d_d;
  logic             lat_en_q, lat_en_d;
  logic             done_q, done_d;
  logic             cnt_clear, cnt_load, cnt_zero;
  logic [CntW-1:0]  cnt_val;
  logic             accept;

  latch_loader_phase_counter #(
    .CNT_W (CntW)
  ) u_phase_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  assign accept = bus.in_valid && bus.in_ready;

  // State, data, gate and done registers; reset drops the gate asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      lat_d_q  <= '0;
      lat_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lat_d_q  <= lat_d_d;
      lat_en_q <= lat_en_d;
      done_q   <= done_d;
    end
  end

  // Next state: flush wins over both accept and phase advance.
  always_comb begin
    state_d   = state_q;
    lat_d_d   = lat_d_q;
    lat_en_d  = lat_en_q;
    done_d    = 1'b0;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    if (flush) begin
      // Data is deliberately kept: the latch may retain a partially-open value.
      state_d   = IDLE;
      lat_en_d  = 1'b0;
      cnt_clear = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            lat_d_d  = bus.in_data;
            cnt_load = 1'b1;
            cnt_val  = CntW'(SETUP_CYC - 1);
            state_d  = SETUP;
          end
        end
        SETUP: begin
          if (cnt_zero) begin
            cnt_load = 1'b1;
            cnt_val  = CntW'(OPEN_CYC - 1);
            lat_en_d = 1'b1;
            state_d  = OPEN;
          end
        end
        OPEN: begin
          if (cnt_zero) begin
            cnt_load = 1'b1;
            cnt_val  = CntW'(HOLD_CYC - 1);
            lat_en_d = 1'b0;
            state_d  = HOLD;
          end
        end
        HOLD: begin
          if (cnt_zero) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: ready/busy decoded from state, latch-facing signals straight from flops.
  always_comb begin
    bus.in_ready = (state_q == IDLE) && !flush;
    busy         = (state_q != IDLE);
    lat_d        = lat_d_q;
    lat_en       = lat_en_q;
    done         = done_q;
  end

endmodule

// File: tb/tb_latch_loader.sv
// Directed bench for latch_loader with a behavioural latch on each DUT's outputs.
module tb_latch_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b1;
  logic       flush, flush2;
  logic [3:0] lat_d, lat_d2, q, q2;
  logic       lat_en, lat_en2, busy, busy2, done, done2;

  latch_loader_if #(.WIDTH(4)) bus ();
  latch_loader_if #(.WIDTH(4)) bus2 ();

  latch_loader dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .flush   (flush),
    .lat_d   (lat_d),
    .lat_en  (lat_en),
    .busy    (busy),
    .done    (done)
  );

  latch_loader #(
    .WIDTH     (4),
    .SETUP_CYC (3),
    .OPEN_CYC  (1),
    .HOLD_CYC  (2)
  ) dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus2.slave),
    .flush   (flush2),
    .lat_d   (lat_d2),
    .lat_en  (lat_en2),
    .busy    (busy2),
    .done    (done2)
  );

  // Positive level-sensitive latches fed by each loader.
  always @(lat_en or lat_d) if (lat_en) q = lat_d;
  always @(lat_en2 or lat_d2) if (lat_en2) q2 = lat_d2;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [3:0] prev_d;
  logic       prev_en;

  // Advance one edge and sample 1 time unit later; data and gate must not move together.
  task automatic tick();
    prev_d  = lat_d;
    prev_en = lat_en;
    @(posedge clk);
    #1;
    if (lat_d !== prev_d) chk("lat_en steady on lat_d edge", lat_en, prev_en);
  endtask

  typedef struct {
    logic en;
    logic busy;
    logic done;
    logic ready;
  } row_t;

  typedef struct {
    logic [3:0] data;
    logic [3:0] exp_q;
  } vec_t;

  row_t tl[6];
  vec_t vec[4];

  logic [7:0] en_pat, done_pat, busy_pat;

  initial begin
    // Expected default-window timeline, row k sampled just after edge E0+k.
    tl[0] = '{en: 1'b0, busy: 1'b1, done: 1'b0, ready: 1'b0};
    tl[1] = '{en: 1'b1, busy: 1'b1, done: 1'b0, ready: 1'b0};
    tl[2] = '{en: 1'b1, busy: 1'b1, done: 1'b0, ready: 1'b0};
    tl[3] = '{en: 1'b0, busy: 1'b1, done: 1'b0, ready: 1'b0};
    tl[4] = '{en: 1'b0, busy: 1'b0, done: 1'b1, ready: 1'b1};
    tl[5] = '{en: 1'b0, busy: 1'b0, done: 1'b0, ready: 1'b1};
    vec[0] = '{data: 4'hA, exp_q: 4'hA};
    vec[1] = '{data: 4'h5, exp_q: 4'h5};
    vec[2] = '{data: 4'hF, exp_q: 4'hF};
    vec[3] = '{data: 4'h0, exp_q: 4'h0};

    flush = 1'b0;  flush2 = 1'b0;
    bus.in_valid = 1'b0;  bus.in_data = 4'h0;
    bus2.in_valid = 1'b0; bus2.in_data = 4'h0;

    // Reset state.
    #2 reset_n = 1'b0;
    #1;
    chk("reset lat_en", lat_en, 1'b0);
    chk("reset lat_d", lat_d, 4'h0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset in_ready", bus.in_ready, 1'b1);
    #19 reset_n = 1'b1;
    tick();
    chk("post-reset in_ready", bus.in_ready, 1'b1);

    // Single loads driven from the vector table.
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = vec[i].data;
      tick();
      bus.in_valid = 1'b0;
      bus.in_data  = ~vec[i].data;
      for (int k = 0; k < 6; k++) begin
        if (k > 0) tick();
        chk($sformatf("load%0d k%0d lat_en", i, k), lat_en, tl[k].en);
        chk($sformatf("load%0d k%0d busy", i, k), busy, tl[k].busy);
        chk($sformatf("load%0d k%0d done", i, k), done, tl[k].done);
        chk($sformatf("load%0d k%0d in_ready", i, k), bus.in_ready, tl[k].ready);
        chk($sformatf("load%0d k%0d lat_d", i, k), lat_d, vec[i].exp_q);
        if (k > 0) chk($sformatf("load%0d k%0d q", i, k), q, vec[i].exp_q);
      end
    end

    // Back-to-back: valid held, second word taken in the done cycle.
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h3;
    tick();
    bus.in_data = 4'hC;
    for (int k = 1; k < 5; k++) begin
      tick();
      chk($sformatf("b2b k%0d lat_d", k), lat_d, 4'h3);
    end
    chk("b2b done", done, 1'b1);
    chk("b2b in_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b second lat_d", lat_d, 4'hC);
    chk("b2b second busy", busy, 1'b1);
    chk("b2b q before open", q, 4'h3);
    tick();
    chk("b2b q after open", q, 4'hC);
    tick(); tick(); tick();
    chk("b2b second done", done, 1'b1);
    tick();

    // Upstream stall: valid toggles while busy, no extra accept.
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h5;
    tick();
    bus.in_data = 4'h9;
    for (int k = 1; k < 4; k++) begin
      bus.in_valid = k[0];
      tick();
      chk($sformatf("stall k%0d lat_d", k), lat_d, 4'h5);
      chk($sformatf("stall k%0d in_ready", k), bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("stall done", done, 1'b1);
    tick();
    chk("stall idle busy", busy, 1'b0);
    chk("stall idle lat_d", lat_d, 4'h5);

    // Flush in OPEN.
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h7;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    chk("flush pre lat_en", lat_en, 1'b1);
    flush = 1'b1;
    #1;
    chk("flush in_ready low", bus.in_ready, 1'b0);
    tick();
    chk("flush lat_en", lat_en, 1'b0);
    chk("flush busy", busy, 1'b0);
    chk("flush lat_d kept", lat_d, 4'h7);
    flush = 1'b0;
    #1;
    chk("flush in_ready", bus.in_ready, 1'b1);
    tick();
    chk("flush no done a", done, 1'b0);
    tick();
    chk("flush no done b", done, 1'b0);

    // Flush beats accept.
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hE;
    tick();
    chk("flush-vs-accept busy", busy, 1'b0);
    chk("flush-vs-accept lat_d", lat_d, 4'h7);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    tick();

    // Reset mid-OPEN.
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h6;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("rst-mid pre lat_en", lat_en, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst-mid lat_en", lat_en, 1'b0);
    chk("rst-mid lat_d", lat_d, 4'h0);
    chk("rst-mid busy", busy, 1'b0);
    #10 reset_n = 1'b1;
    tick();
    chk("rst-mid in_ready", bus.in_ready, 1'b1);
    chk("rst-mid done", done, 1'b0);
    chk("rst-mid lat_en after", lat_en, 1'b0);

    // SETUP=3 OPEN=1 HOLD=2 instance: bit k is the value just after edge E0+k.
    en_pat   = 8'b0000_1000;
    done_pat = 8'b0100_0000;
    busy_pat = 8'b0011_1111;
    bus2.in_valid = 1'b1;
    bus2.in_data  = 4'hB;
    tick();
    bus2.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      chk($sformatf("p2 k%0d lat_en", k), lat_en2, en_pat[k]);
      chk($sformatf("p2 k%0d done", k), done2, done_pat[k]);
      chk($sformatf("p2 k%0d busy", k), busy2, busy_pat[k]);
      chk($sformatf("p2 k%0d lat_d", k), lat_d2, 4'hB);
      if (k >= 3) chk($sformatf("p2 k%0d q", k), q2, 4'hB);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
